serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle N-bit subtractor that computes x - y - bin, least-significant bits first, BITS_PER_CYCLE bits per clock.
- The borrow is held in a flip-flop between steps.
- This is the sequential successor of the single-bit full-subtractor cell. It serves datapaths where area matters more than latency: ALU back-ends and counters that compare wide values.
- A start/busy/done handshake sits on a single clock domain.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH evenly; checked at elaboration.
- STEPS (localparam), WIDTH/BITS_PER_CYCLE, number of compute cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- x  input  WIDTH  minuend, sampled on accept.
- y  input  WIDTH  subtrahend, sampled on accept.
- bin  input  1  borrow-in, sampled on accept.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result x - y - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff x < y + bin (unsigned).
- ovf  output  1  signed (two's-complement) overflow of x - y - bin.
- zero  output  1  diff == 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, bout, ovf = 0; diff = 0; zero = 1; step counter = 0; internal operand and borrow registers = 0.
- States:
  - IDLE: busy=0. start=1 → latch x, y, bin into shift and borrow registers, clear diff, counter=0, go to RUN.
  - RUN: busy=1. Each cycle: the slice subtracts the low BITS_PER_CYCLE bits of the x and y shift registers with the borrow register. The slice difference is shifted into diff from the MSB end. Its borrow-out is written to the borrow register. x and y shift right by BITS_PER_CYCLE. Counter increments.
  - RUN exit: when counter == STEPS-1, the next edge goes to IDLE with done=1 for exactly one cycle. On that same edge, diff, bout and ovf are updated to final values.
- Latency: start accepted on edge N; busy=1 for cycles N+1 … N+STEPS; done=1 in cycle N+STEPS+1 with busy=0. Start-to-done is STEPS+1 edges.
- Results are held stable after done until the next accepted start.
- Ordering on an accepted start: diff clears on accept; bout, ovf and zero update only at done.
- ovf = (x_msb != y_msb) && (diff_msb != x_msb), using the latched operands; bin is included in diff.
- zero is combinational from registered diff.
- start while busy=1 is ignored: no effect on operands, counter or outputs.
- start during the done cycle is accepted, since busy=0. done deasserts next cycle and busy asserts. Back-to-back throughput is one op per STEPS+1 cycles.
- Operand inputs are don't-care except in the accept cycle.
- Reset mid-RUN aborts immediately to reset values. No done is produced for the aborted op.
- Wrap-around: modulo arithmetic. 0 - 1 gives all-ones with bout=1.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN}.
  - A function computing STEPS and the counter width, $clog2(STEPS) with a minimum of 1.
- One sub-module, subtract_slice: combinational BITS_PER_CYCLE-bit ripple-borrow chain.
  - Ports: a, b, borrow_in → d, borrow_out.
  - Built by instantiating the existing full-subtractor cell per bit in a generate loop.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
1. WIDTH=8, BPC=1: x=0x05, y=0x03, bin=0 → done exactly 9 edges after the accept edge; diff=0x02, bout=0, ovf=0, zero=0; busy high for 8 cycles.
2. x=0x00, y=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then x=0x00, y=0x00, bin=1 → diff=0xFF, bout=1.
3. x=0x80, y=0x01 → diff=0x7F, ovf=1, bout=0. x=0x3C, y=0x3C → diff=0x00, zero=1, bout=0.
4. Pulse start with x=0x10, y=0x01; reassert start with x=0xFF, y=0xFF at cycle 3 of busy → ignored; result diff=0x0F. Start asserted in the done cycle → accepted, busy next cycle.
5. Assert rst_n=0 in cycle 4 of RUN → busy=0, diff=0, zero=1 immediately; no done pulse. A new op afterwards completes correctly.
6. WIDTH=16, BPC=4: x=0x1234, y=0x0235 → diff=0x0FFF, bout=0, done 5 edges after accept. Random 1000-op sweep against a reference model for BPC∈{1,2,4,8}.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared types and elaboration helpers for the serial subtractor.
//   - state_e        : control FSM states (IDLE, RUN)
//   - calc_steps     : number of compute cycles for a WIDTH / BITS_PER_CYCLE pair
//   - calc_cnt_width : step-counter width, $clog2(steps) but never below 1
package serial_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int calc_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // A single-step configuration still needs a one-bit counter to exist.
  function automatic int calc_cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   Single-bit full-subtractor cell: d = a - b - bin.
//   Ports:
//     a, b, bin : minuend bit, subtrahend bit, borrow-in
//     d         : difference bit
//     bout      : borrow-out (1 when a < b + bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a == b and a borrow arrives.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtract_slice.sv
// subtract_slice
//   Combinational BITS_PER_CYCLE-bit ripple-borrow subtractor built from
//   full_subtractor cells, LSB first.
//   Ports:
//     a, b       : slice operands
//     borrow_in  : borrow entering bit 0
//     d          : slice difference
//     borrow_out : borrow leaving the MSB of the slice
module subtract_slice #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a,
  input  logic [BITS_PER_CYCLE-1:0] b,
  input  logic                      borrow_in,
  output logic [BITS_PER_CYCLE-1:0] d,
  output logic                      borrow_out
);

  logic [BITS_PER_CYCLE:0] borrow_chain;

  assign borrow_chain[0] = borrow_in;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_bit
    full_subtractor u_fs (
      .a    (a[gi]),
      .b    (b[gi]),
      .bin  (borrow_chain[gi]),
      .d    (d[gi]),
      .bout (borrow_chain[gi+1])
    );
  end

  assign borrow_out = borrow_chain[BITS_PER_CYCLE];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle WIDTH-bit subtractor computing x - y - bin, LSBs first,
//   BITS_PER_CYCLE bits per clock, with the borrow carried in a flop.
//   Ports:
//     clk, rst_n   : clock (rising edge), asynchronous active-low reset
//     start        : request, accepted only while busy = 0
//     x, y, bin    : minuend, subtrahend, borrow-in (sampled on accept)
//     busy         : high while computing
//     done         : one-cycle pulse when diff/bout/ovf are final
//     diff         : x - y - bin modulo 2^WIDTH
//     bout         : final borrow-out (x < y + bin, unsigned)
//     ovf          : two's-complement overflow of the subtraction
//     zero         : diff == 0
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS  = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W  = calc_cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_check
    $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               borrow_q, borrow_d;
  logic               x_msb_q, x_msb_d;
  logic               y_msb_q, y_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic                      slice_bout;
  logic [WIDTH-1:0]          slice_ext;

  subtract_slice #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_slice (
    .a          (x_q[BITS_PER_CYCLE-1:0]),
    .b          (y_q[BITS_PER_CYCLE-1:0]),
    .borrow_in  (borrow_q),
    .d          (slice_d),
    .borrow_out (slice_bout)
  );

  // Slice result positioned at the MSB end of diff; a shift keeps this legal
  // even when one slice covers the whole word.
  assign slice_ext = WIDTH'(slice_d) << (WIDTH - BITS_PER_CYCLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    borrow_d = borrow_q;
    x_msb_d  = x_msb_q;
    y_msb_d  = y_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = x;
          y_d      = y;
          borrow_d = bin;
          // Operand sign bits are kept aside because the shift registers lose them.
          x_msb_d  = x[WIDTH-1];
          y_msb_d  = y[WIDTH-1];
          diff_d   = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        diff_d   = (diff_q >> BITS_PER_CYCLE) | slice_ext;
        x_d      = x_q >> BITS_PER_CYCLE;
        y_d      = y_q >> BITS_PER_CYCLE;
        borrow_d = slice_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
          bout_d  = slice_bout;
          // The last slice supplies the result MSB.
          ovf_d   = (x_msb_q != y_msb_q) && (slice_d[BITS_PER_CYCLE-1] != x_msb_q);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      x_msb_q  <= 1'b0;
      y_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
      x_msb_q  <= x_msb_d;
      y_msb_q  <= y_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = (diff_q == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Four WIDTH=8 instances (BITS_PER_CYCLE = 1, 2, 4, 8) sharing operands with
//   individual start lines, plus one WIDTH=16 / BITS_PER_CYCLE=4 instance.
//   Expected results are queued per instance when an op is driven and popped
//   by a per-instance monitor when done pulses.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef vec_t vec_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      start8;
  logic [7:0]      x8, y8;
  logic            bin8;
  logic [3:0]      busy8, done8, bout8, ovf8, zero8;
  logic [3:0][7:0] diff8;

  logic            start16;
  logic [15:0]     x16, y16;
  logic            bin16;
  logic            busy16, done16, bout16, ovf16, zero16;
  logic [15:0]     diff16;

  int     n_cmp = 0;
  int     n_bad = 0;
  vec_q_t exp_q [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_result(input int idx, input logic [15:0] d, input logic bo,
                              input logic ov, input logic z, input logic bz);
    vec_t e;
    n_cmp++;
    if (exp_q[idx].size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_done inst=%0d: got done with diff=%h, required no done", idx, d);
      return;
    end
    e = exp_q[idx].pop_front();
    $display("op inst=%0d x=%h y=%h bin=%b -> diff=%h bout=%b ovf=%b zero=%b",
             idx, e.x, e.y, e.bin, d, bo, ov, z);
    chk($sformatf("diff inst=%0d x=%h y=%h bin=%b", idx, e.x, e.y, e.bin), 32'(d), 32'(e.diff));
    chk($sformatf("bout inst=%0d x=%h y=%h bin=%b", idx, e.x, e.y, e.bin), 32'(bo), 32'(e.bout));
    chk($sformatf("ovf inst=%0d x=%h y=%h bin=%b", idx, e.x, e.y, e.bin), 32'(ov), 32'(e.ovf));
    chk($sformatf("zero inst=%0d x=%h y=%h bin=%b", idx, e.x, e.y, e.bin), 32'(z), 32'(e.zero));
    chk($sformatf("busy_at_done inst=%0d", idx), 32'(bz), 32'd0);
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_w8
    serial_subtractor #(
      .WIDTH          (8),
      .BITS_PER_CYCLE (1 << gi)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8[gi]),
      .x     (x8),
      .y     (y8),
      .bin   (bin8),
      .busy  (busy8[gi]),
      .done  (done8[gi]),
      .diff  (diff8[gi]),
      .bout  (bout8[gi]),
      .ovf   (ovf8[gi]),
      .zero  (zero8[gi])
    );

    always @(negedge clk) begin
      if (rst_n && done8[gi])
        check_result(gi, {8'h00, diff8[gi]}, bout8[gi], ovf8[gi], zero8[gi], busy8[gi]);
    end
  end

  serial_subtractor #(
    .WIDTH          (16),
    .BITS_PER_CYCLE (4)
  ) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .x     (x16),
    .y     (y16),
    .bin   (bin16),
    .busy  (busy16),
    .done  (done16),
    .diff  (diff16),
    .bout  (bout16),
    .ovf   (ovf16),
    .zero  (zero16)
  );

  always @(negedge clk) begin
    if (rst_n && done16)
      check_result(4, diff16, bout16, ovf16, zero16, busy16);
  end

  // Reference: plain wide arithmetic on the masked operands.
  function automatic vec_t ref_sub(input int w, input logic [15:0] x, input logic [15:0] y,
                                   input logic bin);
    vec_t        r;
    logic [16:0] full;
    logic [15:0] mask;
    logic        xm, ym;
    mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
    r.x    = x & mask;
    r.y    = y & mask;
    r.bin  = bin;
    full   = {1'b0, r.x} - {1'b0, r.y} - {16'b0, bin};
    r.diff = full[15:0] & mask;
    r.bout = ({1'b0, r.x} < ({1'b0, r.y} + {16'b0, bin}));
    xm     = r.x[w-1];
    ym     = r.y[w-1];
    r.ovf  = (xm != ym) && (r.diff[w-1] != xm);
    r.zero = (r.diff == 16'h0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (((busy8 != 4'b0) || busy16) && (k < budget)) begin
      tick();
      k++;
    end
    if ((busy8 != 4'b0) || busy16) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy8=%b busy16=%b after %0d cycles, required idle", busy8, busy16, budget);
    end
  endtask

  task automatic drive8(input logic [3:0] mask, input vec_t e);
    x8   = e.x[7:0];
    y8   = e.y[7:0];
    bin8 = e.bin;
    for (int i = 0; i < 4; i++)
      if (mask[i]) exp_q[i].push_back(e);
    start8 = mask;
    tick();
    start8 = 4'b0;
  endtask

  vec_t tbl [7];

  initial begin
    vec_t e;
    int   edges, busy_cycles, dones;
    logic [15:0] rx, ry;

    tbl[0] = '{x:16'h05, y:16'h03, bin:1'b0, diff:16'h02, bout:1'b0, ovf:1'b0, zero:1'b0};
    tbl[1] = '{x:16'h00, y:16'h01, bin:1'b0, diff:16'hFF, bout:1'b1, ovf:1'b0, zero:1'b0};
    tbl[2] = '{x:16'h00, y:16'h00, bin:1'b1, diff:16'hFF, bout:1'b1, ovf:1'b0, zero:1'b0};
    tbl[3] = '{x:16'h80, y:16'h01, bin:1'b0, diff:16'h7F, bout:1'b0, ovf:1'b1, zero:1'b0};
    tbl[4] = '{x:16'h3C, y:16'h3C, bin:1'b0, diff:16'h00, bout:1'b0, ovf:1'b0, zero:1'b1};
    tbl[5] = '{x:16'h7F, y:16'hFF, bin:1'b0, diff:16'h80, bout:1'b1, ovf:1'b1, zero:1'b0};
    tbl[6] = '{x:16'hFF, y:16'hFF, bin:1'b1, diff:16'hFF, bout:1'b1, ovf:1'b0, zero:1'b0};

    rst_n   = 1'b0;
    start8  = 4'b0;
    x8      = '0;
    y8      = '0;
    bin8    = 1'b0;
    start16 = 1'b0;
    x16     = '0;
    y16     = '0;
    bin16   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("reset_busy", 32'(busy8[0]), 32'd0);
    chk("reset_done", 32'(done8[0]), 32'd0);
    chk("reset_diff", 32'(diff8[0]), 32'd0);
    chk("reset_zero", 32'(zero8[0]), 32'd1);
    chk("reset_bout", 32'(bout8[0]), 32'd0);
    chk("reset_ovf", 32'(ovf8[0]), 32'd0);
    chk("reset_diff16", 32'(diff16), 32'd0);
    chk("reset_zero16", 32'(zero16), 32'd1);
    rst_n = 1'b1;
    tick();

    // Latency and busy length for WIDTH=8, one bit per cycle; the accept edge counts as edge 1.
    x8 = 8'h05; y8 = 8'h03; bin8 = 1'b0;
    exp_q[0].push_back(tbl[0]);
    start8 = 4'b0001;
    tick();
    start8 = 4'b0;
    edges = 1;
    busy_cycles = 0;
    while (!done8[0] && edges < 30) begin
      if (busy8[0]) busy_cycles++;
      tick();
      edges++;
    end
    chk("latency_w8_bpc1", 32'(edges), 32'd9);
    chk("busy_cycles_w8_bpc1", 32'(busy_cycles), 32'd8);
    repeat (3) tick();
    chk("hold_diff_after_done", 32'(diff8[0]), 32'h02);
    chk("hold_zero_after_done", 32'(zero8[0]), 32'd0);

    // Directed table on all four 8-bit widths
    for (int i = 0; i < 7; i++) begin
      wait_idle(40);
      drive8(4'hF, tbl[i]);
    end
    wait_idle(40);

    // Start while busy is ignored; start during done is accepted.
    e = '{x:16'h10, y:16'h01, bin:1'b0, diff:16'h0F, bout:1'b0, ovf:1'b0, zero:1'b0};
    drive8(4'b0001, e);
    tick();
    tick();
    x8 = 8'hFF; y8 = 8'hFF; bin8 = 1'b0;
    start8 = 4'b0001;
    tick();
    start8 = 4'b0;
    x8 = 8'h00; y8 = 8'h00;
    chk("busy_during_ignored_start", 32'(busy8[0]), 32'd1);
    edges = 0;
    while (!done8[0] && edges < 30) begin
      tick();
      edges++;
    end
    chk("done_seen_after_ignored_start", 32'(done8[0]), 32'd1);
    e = '{x:16'h20, y:16'h21, bin:1'b0, diff:16'hFF, bout:1'b1, ovf:1'b0, zero:1'b0};
    drive8(4'b0001, e);
    chk("busy_after_start_in_done_cycle", 32'(busy8[0]), 32'd1);
    chk("done_clears_after_done_cycle", 32'(done8[0]), 32'd0);
    wait_idle(40);

    // Asynchronous reset in the fourth RUN cycle aborts without a done pulse.
    x8 = 8'h55; y8 = 8'h11; bin8 = 1'b0;
    start8 = 4'b0001;
    tick();
    start8 = 4'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) exp_q[i].delete();
    #1;
    chk("abort_busy", 32'(busy8[0]), 32'd0);
    chk("abort_diff", 32'(diff8[0]), 32'd0);
    chk("abort_zero", 32'(zero8[0]), 32'd1);
    chk("abort_done", 32'(done8[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8[0]) dones++;
      tick();
    end
    chk("no_done_after_abort", 32'(dones), 32'd0);
    e = '{x:16'h9A, y:16'h21, bin:1'b1, diff:16'h78, bout:1'b0, ovf:1'b1, zero:1'b0};
    drive8(4'b0001, e);
    wait_idle(40);

    // WIDTH=16, four bits per cycle: accept edge counts as edge 1.
    x16 = 16'h1234; y16 = 16'h0235; bin16 = 1'b0;
    exp_q[4].push_back('{x:16'h1234, y:16'h0235, bin:1'b0, diff:16'h0FFF,
                        bout:1'b0, ovf:1'b0, zero:1'b0});
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    edges = 1;
    while (!done16 && edges < 30) begin
      tick();
      edges++;
    end
    chk("latency_w16_bpc4", 32'(edges), 32'd5);
    wait_idle(40);

    // Random sweep with a bias toward corner operands
    for (int n = 0; n < 1000; n++) begin
      wait_idle(40);
      rx = 16'($urandom);
      ry = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rx = 16'h0000;
        1: ry = 16'hFFFF;
        2: begin rx = 16'h0080; ry = 16'h8001; end
        3: begin rx = 16'h7FFF; ry = 16'h00FF; end
        default: ;
      endcase
      bin8  = 1'($urandom);
      bin16 = bin8;
      x8    = rx[7:0];
      y8    = ry[7:0];
      x16   = rx;
      y16   = ry;
      for (int i = 0; i < 4; i++) exp_q[i].push_back(ref_sub(8, rx, ry, bin8));
      exp_q[4].push_back(ref_sub(16, rx, ry, bin16));
      start8  = 4'hF;
      start16 = 1'b1;
      tick();
      start8  = 4'b0;
      start16 = 1'b0;
    end
    wait_idle(40);
    repeat (3) tick();

    for (int i = 0; i < 5; i++)
      chk($sformatf("pending_results inst=%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
